// File: rtl/clm_sbox_pipe_if.sv
// params_if -- public masking parameters shared by every S-box lane.
//   B_ext, T, t : 8-bit public constants. clm_sbox_pipe folds them into one
//                 offset that is XORed equally into both output shares. This
//                 changes the masked representation but never the decoded value.
interface params_if;
   logic [7:0] B_ext;
   logic [7:0] T;
   logic [7:0] t;
   modport in_use (input B_ext, input T, input t);
endinterface

// File: rtl/clm_sbox_pipe.sv
// clm_sbox_pipe -- masked AES S-box pipeline, LANES lanes sharing one valid/ready.
// Word layout (state_t, 8+d bits): {share1[d-1:0], share0[7:0]}, value = share0 ^ share1.
// share1 is a full GF(2^8) element, so d is 8.
// Chain per lane: x^2, x^3, x^12, x^14/x^15, x^240, x^254, then affine_transform.
// Every gadget uses its own in_r word; the word is folded to one fresh byte.
// Ports:
//   clk, rst (async active-low), params (B_ext/T/t output mask offset)
//   in_valid/in_ready/in_data/in_r : input handshake, masked bytes, 7 random words per lane
//   flush : synchronous discard of every in-flight item
//   out_valid/out_ready/out_data : output handshake, masked S-box results
//   occupancy : number of valid pipeline stages
// Option: define CLM_SBOX_OUTREG_EN to register the affine output (stage S6, latency 7).
module clm_sbox_pipe #(
   parameter int d     = 8,
   parameter int LANES = 1,
   localparam int W    = 8 + d
) (
   input  logic                          clk,
   input  logic                          rst,
   params_if.in_use                      params,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES-1:0][W-1:0]       in_data,
   input  logic [LANES-1:0][6:0][W-1:0]  in_r,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0][W-1:0]       out_data,
   output logic [2:0]                    occupancy
);

`ifdef CLM_SBOX_OUTREG_EN
   localparam int NST = 7;
`else
   localparam int NST = 6;
`endif

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (aa & {8{b[i]}});
         aa = {aa[6:0], 1'b0} ^ (8'h1B & {8{aa[7]}});
      end
      return p;
   endfunction

   function automatic logic [7:0] fold(input logic [W-1:0] r);
      return r[W-1:8] ^ r[7:0];
   endfunction

   // Squaring is linear over GF(2^8), so it acts per share. A refresh then
   // re-randomises the share split.
   function automatic logic [W-1:0] m_pow(input logic [W-1:0] w, input int n, input logic [W-1:0] r);
      logic [7:0] s0;
      logic [7:0] s1;
      logic [7:0] rr;
      s0 = w[7:0];
      s1 = w[W-1:8];
      for (int i = 0; i < 4; i++) begin
         s0 = (i < n) ? gf_mul(s0, s0) : s0;
         s1 = (i < n) ? gf_mul(s1, s1) : s1;
      end
      rr = fold(r);
      return {s1 ^ rr, s0 ^ rr};
   endfunction

   // Two-share ISW product. The random byte goes in before the cross terms.
   function automatic logic [W-1:0] m_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
      logic [7:0] rr;
      logic [7:0] c0;
      logic [7:0] c1;
      rr = fold(r);
      c0 = gf_mul(a[7:0], b[7:0]) ^ rr;
      c1 = gf_mul(a[W-1:8], b[W-1:8]) ^ ((rr ^ gf_mul(a[7:0], b[W-1:8])) ^ gf_mul(a[W-1:8], b[7:0]));
      return {c1, c0};
   endfunction

   function automatic logic [7:0] aff_lin(input logic [7:0] b);
      logic [7:0] o;
      for (int i = 0; i < 8; i++) begin
         o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
      end
      return o;
   endfunction

   // The constant 0x63 goes into one share only. The public offset goes into both shares.
   function automatic logic [W-1:0] m_affine(input logic [W-1:0] w, input logic [7:0] pub);
      return {aff_lin(w[W-1:8]) ^ pub, aff_lin(w[7:0]) ^ 8'h63 ^ pub};
   endfunction

   logic [NST-1:0] valid;
   logic           run;
   logic           advance;
   logic           in_xfer;
   logic [7:0]     pub;

   assign out_valid = valid[NST-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = run && advance && !flush;
   assign in_xfer   = in_valid && in_ready;
   assign pub       = params.B_ext ^ params.T ^ params.t;

   // Stage valid bits, plus the flag that keeps in_ready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         run   <= 1'b0;
      end else begin
         run <= 1'b1;
         if (flush) begin
            valid <= '0;
         end else if (advance) begin
            valid <= {valid[NST-2:0], in_xfer};
         end
      end
   end

   // Count the set stage valid bits.
   always_comb begin
      occupancy = 3'd0;
      for (int i = 0; i < NST; i++) begin
         occupancy = occupancy + {2'b00, valid[i]};
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [W-1:0]      s0_t1, s0_t2, s1_t2, s1_t3, s2_t2, s2_t3, s2_t12;
      logic [W-1:0]      s3_t14, s3_t15, s4_t14, s4_t240, s4_r6, s5_t254;
      logic [6:1][W-1:0] s0_r;
      logic [6:2][W-1:0] s1_r;
      logic [6:3][W-1:0] s2_r;
      logic [6:5][W-1:0] s3_r;

      // Lane datapath. Operands and unused randomness move together, so each
      // gadget uses the words captured when its own item was accepted.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s0_t1 <= '0; s0_t2 <= '0; s0_r <= '0;
            s1_t2 <= '0; s1_t3 <= '0; s1_r <= '0;
            s2_t2 <= '0; s2_t3 <= '0; s2_t12 <= '0; s2_r <= '0;
            s3_t14 <= '0; s3_t15 <= '0; s3_r <= '0;
            s4_t14 <= '0; s4_t240 <= '0; s4_r6 <= '0;
            s5_t254 <= '0;
         end else if (advance) begin
            s0_t1   <= in_data[l];
            s0_t2   <= m_pow(in_data[l], 1, in_r[l][0]);
            s0_r    <= in_r[l][6:1];
            s1_t2   <= s0_t2;
            s1_t3   <= m_mul(s0_t1, s0_t2, s0_r[1]);
            s1_r    <= s0_r[6:2];
            s2_t2   <= s1_t2;
            s2_t3   <= s1_t3;
            s2_t12  <= m_pow(s1_t3, 2, s1_r[2]);
            s2_r    <= s1_r[6:3];
            s3_t14  <= m_mul(s2_t2, s2_t12, s2_r[3]);
            s3_t15  <= m_mul(s2_t3, s2_t12, s2_r[4]);
            s3_r    <= s2_r[6:5];
            s4_t14  <= s3_t14;
            s4_t240 <= m_pow(s3_t15, 4, s3_r[5]);
            s4_r6   <= s3_r[6];
            s5_t254 <= m_mul(s4_t14, s4_t240, s4_r6);
         end
      end

`ifdef CLM_SBOX_OUTREG_EN
      logic [W-1:0] s6_out;

      // Registered affine output stage.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s6_out <= '0;
         end else if (advance) begin
            s6_out <= m_affine(s5_t254, pub);
         end
      end

      assign out_data[l] = s6_out;
`else
      assign out_data[l] = m_affine(s5_t254, pub);
`endif
   end

endmodule

// File: tb/tb_clm_sbox_pipe.sv
// Self-checking bench for clm_sbox_pipe with 4 lanes. Expected bytes come from
// an AES S-box. The bench builds that table as the GF(2^8) inverse followed by
// the rotate-XOR affine map.
module tb_clm_sbox_pipe;

`ifdef CLM_SBOX_OUTREG_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 6;
`endif
   localparam int LN = 4;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [LN-1:0][15:0]         in_data = '0;
   logic [LN-1:0][6:0][15:0]    in_r = '0;
   logic                        flush = 1'b0;
   logic                        out_valid;
   logic                        out_ready = 1'b1;
   logic [LN-1:0][15:0]         out_data;
   logic [2:0]                  occupancy;
   int                          checks = 0;
   int                          errors = 0;
   logic [7:0]                  sbox_t [256];

   params_if pif ();

   clm_sbox_pipe #(.d(8), .LANES(LN)) dut (
      .clk(clk), .rst(rst), .params(pif), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_r(in_r), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Carry-less product reduced by the AES polynomial, from the top bit down.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [7:0] dec(input logic [15:0] w);
      return w[7:0] ^ w[15:8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_item(input logic [LN-1:0][7:0] b);
      logic [7:0] mk;
      in_valid = 1'b1;
      for (int l = 0; l < LN; l++) begin
         mk = 8'($urandom);
         in_data[l] = {mk, b[l] ^ mk};
         for (int w = 0; w < 7; w++) in_r[l][w] = 16'($urandom);
      end
   endtask

   function automatic logic [LN-1:0][7:0] rand_bytes();
      logic [LN-1:0][7:0] b;
      for (int l = 0; l < LN; l++) b[l] = 8'($urandom);
      return b;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready_early: got %b want 0", in_ready); end
      tick();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_directed();
      logic [7:0]         din [3];
      logic [7:0]         dout [3];
      logic [LN-1:0][7:0] b;
      int                 occ_exp;
      logic               exp_v;
      din  = '{8'h00, 8'h01, 8'h53};
      dout = '{8'h63, 8'h7C, 8'hED};
      out_ready = 1'b1;
      for (int c = 0; c < LAT + 4; c++) begin
         if (c < 3) begin
            for (int l = 0; l < LN; l++) b[l] = din[c];
            drive_item(b);
         end else in_valid = 1'b0;
         @(negedge clk);
         if (c < 3) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready c=%0d: got %b want 1", c, in_ready); end
         end
         occ_exp = 0;
         for (int i = 0; i < 3; i++) if (c >= i + 1 && c <= i + LAT) occ_exp++;
         checks++; if (occupancy !== 3'(occ_exp)) begin errors++; $display("FAIL directed_occupancy c=%0d: got %0d want %0d", c, occupancy, occ_exp); end
         exp_v = (c >= LAT && c < LAT + 3);
         checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL directed_out_valid c=%0d: got %b want %b", c, out_valid, exp_v); end
         if (exp_v) begin
            for (int l = 0; l < LN; l++) begin
               checks++;
               if (dec(out_data[l]) !== dout[c - LAT]) begin errors++; $display("FAIL directed_data c=%0d lane=%0d: got %h want %h", c, l, dec(out_data[l]), dout[c - LAT]); end
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [LN-1:0][7:0] b;
      logic               exp_v;
      logic [7:0]         e;
      int                 k;
      out_ready = 1'b1;
      for (int c = 0; c < 256 + LAT + 2; c++) begin
         if (c < 256) begin
            for (int l = 0; l < LN; l++) b[l] = 8'(c + 64 * l);
            drive_item(b);
         end else in_valid = 1'b0;
         @(negedge clk);
         if (c < 256) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready); end
         end
         k = c - LAT;
         exp_v = (k >= 0 && k < 256);
         checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_out_valid c=%0d: got %b want %b", c, out_valid, exp_v); end
         if (exp_v) begin
            for (int l = 0; l < LN; l++) begin
               e = sbox_t[8'(k + 64 * l)];
               checks++;
               if (dec(out_data[l]) !== e) begin errors++; $display("FAIL b2b_data k=%0d lane=%0d: got %h want %h", k, l, dec(out_data[l]), e); end
            end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [LN-1:0][7:0] cur;
      logic [LN-1:0][7:0] ex;
      logic [LN-1:0][7:0] q [$];
      logic [LN-1:0][15:0] held;
      logic               stall;
      logic               xfer;
      int                 acc;
      int                 got;
      acc = 0;
      got = 0;
      held = '0;
      cur = rand_bytes();
      drive_item(cur);
      for (int c = 0; c < 80 && got < 10; c++) begin
         stall = (c >= LAT + 1 && c < LAT + 6);
         out_ready = !stall;
         @(negedge clk);
         if (stall) begin
            checks++; if (occupancy !== 3'(LAT)) begin errors++; $display("FAIL stall_occupancy c=%0d: got %0d want %0d", c, occupancy, LAT); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid c=%0d: got %b want 1", c, out_valid); end
            if (c == LAT + 1) held = out_data;
            else begin
               checks++; if (out_data !== held) begin errors++; $display("FAIL stall_hold c=%0d: got %h want %h", c, out_data, held); end
            end
         end
         if (out_valid && out_ready) begin
            got++;
            if (q.size() == 0) begin
               checks++; errors++; $display("FAIL stall_extra_output c=%0d: got output want none", c);
            end else begin
               ex = q.pop_front();
               for (int l = 0; l < LN; l++) begin
                  checks++;
                  if (dec(out_data[l]) !== sbox_t[ex[l]]) begin errors++; $display("FAIL stall_data c=%0d lane=%0d: got %h want %h", c, l, dec(out_data[l]), sbox_t[ex[l]]); end
               end
            end
         end
         xfer = in_valid && in_ready;
         if (xfer) begin
            q.push_back(cur);
            acc++;
         end
         tick();
         if (acc >= 10) in_valid = 1'b0;
         else if (xfer) begin
            cur = rand_bytes();
            drive_item(cur);
         end
      end
      out_ready = 1'b1;
      checks++; if (got !== 10 || q.size() !== 0) begin errors++; $display("FAIL stall_count: got %0d outputs (%0d pending) want 10", got, q.size()); end
      @(negedge clk);
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stall_drain_occupancy: got %0d want 0", occupancy); end
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive_item(rand_bytes());
         @(negedge clk);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_fill_ready c=%0d: got %b want 1", c, in_ready); end
         tick();
      end
      flush = 1'b1;
      drive_item(rand_bytes());
      @(negedge clk);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL flush_pre_occupancy: got %0d want 4", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
         end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid c=%0d: got %b want 0", c, out_valid); end
         tick();
      end
   endtask

   task automatic test_reset_midflight();
      logic [LN-1:0][7:0] b;
      logic               exp_v;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive_item(rand_bytes());
         @(negedge clk);
         tick();
      end
      in_valid = 1'b0;
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL midrst_pre_occupancy: got %0d want 3", occupancy); end
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL midrst_occupancy: got %0d want 0", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      for (int c = 0; c < LAT + 3; c++) begin
         if (c == 0) begin
            for (int l = 0; l < LN; l++) b[l] = 8'h00;
            drive_item(b);
         end else in_valid = 1'b0;
         @(negedge clk);
         if (c == 0) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", in_ready); end
         end
         exp_v = (c == LAT);
         checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL midrst_out_valid c=%0d: got %b want %b", c, out_valid, exp_v); end
         if (exp_v) begin
            for (int l = 0; l < LN; l++) begin
               checks++;
               if (dec(out_data[l]) !== 8'h63) begin errors++; $display("FAIL midrst_data lane=%0d: got %h want 63", l, dec(out_data[l])); end
            end
         end
         tick();
      end
   endtask

   task automatic test_masks();
      logic [LN-1:0][7:0]  b;
      logic [LN-1:0][15:0] o1;
      logic [LN-1:0][15:0] o2;
      logic [7:0]          x;
      o1 = '0;
      o2 = '0;
      x = 8'($urandom);
      for (int l = 0; l < LN; l++) b[l] = x;
      out_ready = 1'b1;
      for (int c = 0; c < LAT + 3; c++) begin
         if (c < 2) drive_item(b);
         else in_valid = 1'b0;
         @(negedge clk);
         if (c == LAT) o1 = out_data;
         if (c == LAT + 1) o2 = out_data;
         if (c == LAT || c == LAT + 1) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL masks_out_valid c=%0d: got %b want 1", c, out_valid); end
         end
         tick();
      end
      checks++; if (o1 === o2) begin errors++; $display("FAIL masks_differ: got %h twice want distinct encodings", o1); end
      for (int l = 0; l < LN; l++) begin
         checks++;
         if (dec(o1[l]) !== sbox_t[x] || dec(o2[l]) !== sbox_t[x]) begin
            errors++; $display("FAIL masks_decode lane=%0d: got %h/%h want %h", l, dec(o1[l]), dec(o2[l]), sbox_t[x]);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pif.B_ext = 8'($urandom);
      pif.T     = 8'($urandom);
      pif.t     = 8'($urandom);
      build_sbox();
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_midflight();
      test_masks();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
